// File: rtl/parity_pkg.sv
// Shared types and helpers for the round-robin parity arbiter.
// Optional served counters are enabled with the PARITY_STATS_EN macro.
package parity_pkg;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_CNT_W  = 16;
    localparam int ID_W       = $clog2(DEF_N_REQ);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    // Index of the first set request at or after ptr, wrapping modulo n.
    function automatic int rr_pick(input logic [15:0] req, input int ptr, input int n);
        int   pick;
        int   idx;
        logic found;
        pick  = 0;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i < n) begin
                idx = (ptr + i) % n;
                if (!found && req[4'(idx)]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/parity_unit.sv
// Combinational even-parity generator: XOR-reduction of one word.
module parity_unit #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] word,
    output logic              parity
);

    assign parity = ^word;

endmodule

// File: rtl/parity_arbiter.sv
// Round-robin arbiter sharing one parity unit among N_REQ requesters.
// Define PARITY_STATS_EN to add per-requester served counters (served_cnt).
module parity_arbiter
    import parity_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W
`ifdef PARITY_STATS_EN
    ,
    parameter int CNT_W  = DEF_CNT_W
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   data,
    output logic [N_REQ-1:0]          gnt,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_parity,
    output logic [$clog2(N_REQ)-1:0]  rsp_id,
    output logic                      busy
`ifdef PARITY_STATS_EN
    ,
    output logic [N_REQ*CNT_W-1:0]    served_cnt
`endif
);

    localparam int ID_BITS = $clog2(N_REQ);

    state_t              state;
    state_t              next_state;
    logic [ID_BITS-1:0]  rr_ptr;
    logic [ID_BITS-1:0]  pick_id;
    logic [ID_BITS-1:0]  next_ptr;
    logic [ID_BITS-1:0]  id_q;
    logic [DATA_W-1:0]   word_q;
    logic                grant_fire;
    logic                parity_bit;

    assign pick_id  = ID_BITS'(rr_pick(16'(req), int'(rr_ptr), N_REQ));
    assign next_ptr = (pick_id == ID_BITS'(N_REQ - 1)) ? '0 : pick_id + 1'b1;

    parity_unit #(
        .DATA_W (DATA_W)
    ) u_parity (
        .word   (word_q),
        .parity (parity_bit)
    );

    // Grant is gated by rst_n so it reads zero while reset is held.
    always_comb begin
        next_state = state;
        grant_fire = 1'b0;
        gnt        = '0;
        case (state)
            IDLE: begin
                if ((|req) && rst_n) begin
                    grant_fire   = 1'b1;
                    gnt[pick_id] = 1'b1;
                    next_state   = CALC;
                end
            end
            CALC: next_state = RESP;
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            word_q     <= '0;
            id_q       <= '0;
            rsp_parity <= 1'b0;
        end else begin
            state <= next_state;
            if (grant_fire) begin
                word_q <= data[pick_id*DATA_W +: DATA_W];
                id_q   <= pick_id;
                rr_ptr <= next_ptr;
            end
            if (state == CALC) begin
                rsp_parity <= parity_bit;
            end
        end
    end

    assign rsp_valid = (state == RESP);
    assign rsp_id    = id_q;
    assign busy      = (state != IDLE);

`ifdef PARITY_STATS_EN
    logic [CNT_W-1:0] cnt_q [N_REQ];

    // Counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (rsp_valid && rsp_ready) begin
            cnt_q[id_q] <= cnt_q[id_q] + 1'b1;
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt_out
        assign served_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_parity_arbiter.sv
// Directed self-checking bench for parity_arbiter (N_REQ=4, DATA_W=16).
// Define PARITY_STATS_EN to also exercise the served counters (CNT_W=2).
module tb_parity_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] data;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_parity;
    logic [1:0]  rsp_id;
    logic        busy;

    int n_checks;
    int n_errors;

`ifdef PARITY_STATS_EN
    logic [7:0] served_cnt;

    parity_arbiter #(.N_REQ(4), .DATA_W(16), .CNT_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .data       (data),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_parity (rsp_parity),
        .rsp_id     (rsp_id),
        .busy       (busy),
        .served_cnt (served_cnt)
    );
`else
    parity_arbiter #(.N_REQ(4), .DATA_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .data       (data),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_parity (rsp_parity),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        rsp_ready = 1'b0;
        data      = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        req = 4'b1111;
        rst_n = 1'b0;
        #3;
        n_checks++; if (gnt !== 4'b0000) begin n_errors++; $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (rsp_id !== 2'd0) begin n_errors++; $display("[TB] FAIL reset_id: got %0d expected 0", rsp_id); end
        do_reset();
        // Serve requester 1 so rr_ptr moves to 2, then reset inside RESP.
        req = 4'b0010;
        data[16 +: 16] = 16'h0001;
        rsp_ready = 1'b0;
        step();
        req = 4'b0000;
        step();
        n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("[TB] FAIL pre_reset_valid: got %b expected 1", rsp_valid); end
        #2 rst_n = 1'b0;
        req = 4'b1111;
        #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL midresp_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("[TB] FAIL midresp_busy: got %b expected 0", busy); end
        n_checks++; if (gnt !== 4'b0000) begin n_errors++; $display("[TB] FAIL midresp_gnt: got %b expected 0000", gnt); end
        n_checks++; if (rsp_parity !== 1'b0) begin n_errors++; $display("[TB] FAIL midresp_parity: got %b expected 0", rsp_parity); end
        n_checks++; if (rsp_id !== 2'd0) begin n_errors++; $display("[TB] FAIL midresp_id: got %0d expected 0", rsp_id); end
        step();
        rst_n = 1'b1;
        #1;
        n_checks++; if (gnt !== 4'b0001) begin n_errors++; $display("[TB] FAIL rrptr_after_reset: got %b expected 0001", gnt); end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        data[0 +: 16] = 16'h0001;
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (gnt !== 4'b0001) begin n_errors++; $display("[TB] FAIL single_gnt: got %b expected 0001", gnt); end
        step();
        req = 4'b0000;
        #1;
        n_checks++; if (gnt !== 4'b0000) begin n_errors++; $display("[TB] FAIL single_gnt_pulse: got %b expected 0000", gnt); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL single_valid_t1: got %b expected 0", rsp_valid); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
        step();
        n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("[TB] FAIL single_valid_t2: got %b expected 1", rsp_valid); end
        n_checks++; if (rsp_parity !== 1'b1) begin n_errors++; $display("[TB] FAIL single_parity: got %b expected 1", rsp_parity); end
        n_checks++; if (rsp_id !== 2'd0) begin n_errors++; $display("[TB] FAIL single_id: got %0d expected 0", rsp_id); end
        step();
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL single_done_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("[TB] FAIL single_done_busy: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt [5];
        logic       exp_par [5];
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_par = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        data = {16'h8000, 16'hFFFF, 16'h0007, 16'h0003};
        req = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (gnt !== exp_gnt[k]) begin n_errors++; $display("[TB] FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, exp_gnt[k]); end
            step();
            step();
            n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("[TB] FAIL rr_valid[%0d]: got %b expected 1", k, rsp_valid); end
            n_checks++; if (rsp_parity !== exp_par[k]) begin n_errors++; $display("[TB] FAIL rr_parity[%0d]: got %b expected %b", k, rsp_parity, exp_par[k]); end
            n_checks++; if (rsp_id !== 2'(k % 4)) begin n_errors++; $display("[TB] FAIL rr_id[%0d]: got %0d expected %0d", k, rsp_id, k % 4); end
            step();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 4'b0010;
        data[16 +: 16] = 16'h00F1;
        rsp_ready = 1'b0;
        #1;
        step();
        req = 4'b1111;
        step();
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", c, rsp_valid); end
            n_checks++; if (rsp_parity !== 1'b1) begin n_errors++; $display("[TB] FAIL bp_parity[%0d]: got %b expected 1", c, rsp_parity); end
            n_checks++; if (rsp_id !== 2'd1) begin n_errors++; $display("[TB] FAIL bp_id[%0d]: got %0d expected 1", c, rsp_id); end
            n_checks++; if (gnt !== 4'b0000) begin n_errors++; $display("[TB] FAIL bp_gnt[%0d]: got %b expected 0000", c, gnt); end
            step();
        end
        rsp_ready = 1'b1;
        step();
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL bp_released: got %b expected 0", rsp_valid); end
        n_checks++; if (gnt !== 4'b0100) begin n_errors++; $display("[TB] FAIL bp_next_gnt: got %b expected 0100", gnt); end
    endtask

    task automatic test_lone_requester();
        logic [15:0] words [3];
        logic        exp_par [3];
        words   = '{16'h0000, 16'h0B00, 16'hF00F};
        exp_par = '{1'b0, 1'b1, 1'b0};
        do_reset();
        req = 4'b0100;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data[32 +: 16] = words[k];
            #1;
            n_checks++; if (gnt !== 4'b0100) begin n_errors++; $display("[TB] FAIL lone_gnt[%0d]: got %b expected 0100", k, gnt); end
            step();
            step();
            n_checks++; if (rsp_id !== 2'd2) begin n_errors++; $display("[TB] FAIL lone_id[%0d]: got %0d expected 2", k, rsp_id); end
            n_checks++; if (rsp_parity !== exp_par[k]) begin n_errors++; $display("[TB] FAIL lone_parity[%0d]: got %b expected %b", k, rsp_parity, exp_par[k]); end
            step();
        end
    endtask

`ifdef PARITY_STATS_EN
    task automatic test_stats_wrap();
        do_reset();
        req = 4'b0010;
        data[16 +: 16] = 16'h1234;
        rsp_ready = 1'b1;
        repeat (15) step();
        req = 4'b0000;
        step();
        n_checks++; if (served_cnt[3:2] !== 2'd1) begin n_errors++; $display("[TB] FAIL stats_cnt1: got %0d expected 1", served_cnt[3:2]); end
        n_checks++; if (served_cnt[1:0] !== 2'd0) begin n_errors++; $display("[TB] FAIL stats_cnt0: got %0d expected 0", served_cnt[1:0]); end
        n_checks++; if (served_cnt[7:4] !== 4'd0) begin n_errors++; $display("[TB] FAIL stats_cnt23: got %h expected 0", served_cnt[7:4]); end
    endtask
`endif

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        req       = '0;
        data      = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_lone_requester();
`ifdef PARITY_STATS_EN
        test_stats_wrap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
